// File: rtl/fir_tcdm_slice.sv
// Per-channel TCDM request/response retiming slice: request FIFO, registered
// response stage and outstanding limiter per channel, with an idle-switched bypass.
`timescale 1ns/1ps
module fir_tcdm_slice #(
  parameter int unsigned MP        = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     bypass_i,
  input  logic [MP-1:0]            in_req,
  output logic [MP-1:0]            in_gnt,
  input  logic [MP-1:0][AW-1:0]    in_add,
  input  logic [MP-1:0]            in_wen,
  input  logic [MP-1:0][DW/8-1:0]  in_be,
  input  logic [MP-1:0][DW-1:0]    in_data,
  output logic [MP-1:0][DW-1:0]    in_r_data,
  output logic [MP-1:0]            in_r_valid,
  output logic [MP-1:0]            tcdm_req,
  input  logic [MP-1:0]            tcdm_gnt,
  output logic [MP-1:0][AW-1:0]    tcdm_add,
  output logic [MP-1:0]            tcdm_wen,
  output logic [MP-1:0][DW/8-1:0]  tcdm_be,
  output logic [MP-1:0][DW-1:0]    tcdm_data,
  input  logic [MP-1:0][DW-1:0]    tcdm_r_data,
  input  logic [MP-1:0]            tcdm_r_valid,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned FW = AW + 1 + BW + DW;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  localparam logic [PW-1:0] L_PTR_ONE = 1;
  localparam logic [PW:0]   L_OCC_ONE = 1;
  localparam logic [PW:0]   L_OCC_FULL = DEPTH[PW:0];
  localparam logic [CW-1:0] L_CNT_ONE = 1;
  localparam logic [CW-1:0] L_CNT_MAX = MAX_OUTST[CW-1:0];

  typedef enum logic {MODE_BUF = 1'b0, MODE_BYP = 1'b1} mode_e;

  mode_e         r_mode_q;
  logic          r_err;
  logic          w_byp;
  logic [MP-1:0] w_busy_ch;
  logic [MP-1:0] w_spur;

  assign w_byp  = (r_mode_q == MODE_BYP);
  assign busy_o = |w_busy_ch;
  assign err_o  = r_err;

  // Mode only follows bypass_i while nothing is queued or in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode_q <= MODE_BUF;
    end else if (!busy_o) begin
      r_mode_q <= bypass_i ? MODE_BYP : MODE_BUF;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (clear_i) begin
      r_err <= 1'b0;
    end else if (|w_spur) begin
      r_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < MP; g++) begin : g_ch
    logic [FW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [PW:0]    r_occ;
    logic [CW-1:0]  r_cnt;
    logic           r_rvalid;
    logic [DW-1:0]  r_rdata;
    logic           w_full;
    logic           w_empty;
    logic           w_buf_req;
    logic           w_push;
    logic           w_pop;
    logic           w_dec;
    logic [FW-1:0]  w_head;

    assign w_full    = (r_occ == L_OCC_FULL);
    assign w_empty   = (r_occ == '0);
    assign w_buf_req = ~w_empty & (r_cnt < L_CNT_MAX);
    assign w_push    = ~w_byp & in_req[g] & ~w_full & ~clear_i;
    assign w_pop     = ~w_byp & w_buf_req & tcdm_gnt[g];
    assign w_dec     = ~w_byp & tcdm_r_valid[g] & (r_cnt != '0);
    assign w_head    = r_mem[r_rptr];

    assign w_spur[g]    = ~w_byp & tcdm_r_valid[g] & (r_cnt == '0);
    assign w_busy_ch[g] = ~w_empty | (r_cnt != '0);

    // Clear drops queued entries but a pop granted in the same cycle still counts as issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (clear_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= {in_add[g], in_wen[g], in_be[g], in_data[g]};
          r_wptr        <= r_wptr + L_PTR_ONE;
        end
        if (w_pop) r_rptr <= r_rptr + L_PTR_ONE;
        if (w_push && !w_pop)      r_occ <= r_occ + L_OCC_ONE;
        else if (w_pop && !w_push) r_occ <= r_occ - L_OCC_ONE;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (w_pop && !w_dec) begin
        r_cnt <= r_cnt + L_CNT_ONE;
      end else if (w_dec && !w_pop) begin
        r_cnt <= r_cnt - L_CNT_ONE;
      end
    end

    // Response stage is frozen in bypass so a late switch cannot replay a response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= ~w_byp & tcdm_r_valid[g];
        if (!w_byp) r_rdata <= tcdm_r_data[g];
      end
    end

    assign in_gnt[g]     = w_byp ? tcdm_gnt[g]     : ~w_full;
    assign tcdm_req[g]   = w_byp ? in_req[g]       : w_buf_req;
    assign in_r_valid[g] = w_byp ? tcdm_r_valid[g] : r_rvalid;
    assign in_r_data[g]  = w_byp ? tcdm_r_data[g]  : r_rdata;
    assign {tcdm_add[g], tcdm_wen[g], tcdm_be[g], tcdm_data[g]} =
      w_byp ? {in_add[g], in_wen[g], in_be[g], in_data[g]} : w_head;
  end

endmodule

// File: tb/tb_fir_tcdm_slice.sv
// Scoreboard bench for fir_tcdm_slice: accelerator driver, interconnect model and directed/random tests.
`timescale 1ns/1ps
module tb_fir_tcdm_slice;
  localparam int MP = 4, AW = 32, DW = 32, BW = 4, DEPTH = 2, MAXO = 4;

  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } req_t;

  typedef struct packed {
    logic [31:0]   due;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, bypass = 1'b0;
  logic [MP-1:0]          in_req = '0, in_gnt, in_wen = '0, in_r_valid;
  logic [MP-1:0][AW-1:0]  in_add = '0;
  logic [MP-1:0][BW-1:0]  in_be = '0;
  logic [MP-1:0][DW-1:0]  in_data = '0, in_r_data;
  logic [MP-1:0]          tcdm_req, tcdm_gnt = '1, tcdm_wen, tcdm_r_valid = '0;
  logic [MP-1:0][AW-1:0]  tcdm_add;
  logic [MP-1:0][BW-1:0]  tcdm_be;
  logic [MP-1:0][DW-1:0]  tcdm_data, tcdm_r_data = '0;
  logic busy_o, err_o;

  fir_tcdm_slice #(.MP(MP), .AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bypass_i(bypass),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
    .tcdm_r_valid(tcdm_r_valid), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_err = 0;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  req_t          stim_q    [MP][$];
  req_t          exp_req_q [MP][$];
  rsp_t          pend_q    [MP][$];
  logic [DW-1:0] exp_rsp_q [MP][$];
  req_t          cur_req   [MP];

  logic [MP-1:0] gnt_val = '1, rsp_hold = '0, spur = '0;
  bit            gnt_rand = 0, gap_en = 0, rd_force_en = 0;
  int unsigned   rsp_credit [MP];
  int unsigned   n_grant [MP], n_rsp [MP], n_spur [MP];
  int unsigned   dly_min = 1, dly_max = 1, cyc = 0;
  logic [DW-1:0] rd_force = '0, spur_data = '0;

  // Environment: samples handshakes mid-cycle, drives both sides just after the edge.
  initial begin
    logic [MP-1:0] acc;
    req_t r;
    rsp_t p;
    logic [DW-1:0] e;
    acc = '0;
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < MP; ch++) begin
        acc[ch] = in_req[ch] & in_gnt[ch];
        if (acc[ch]) exp_req_q[ch].push_back(cur_req[ch]);
        if (tcdm_req[ch] && tcdm_gnt[ch]) begin
          chk_eq($sformatf("issue_expected_ch%0d", ch), exp_req_q[ch].size() != 0, 1);
          if (exp_req_q[ch].size() != 0) begin
            r = exp_req_q[ch].pop_front();
            chk_eq($sformatf("issue_fields_ch%0d", ch),
                   {tcdm_add[ch], tcdm_wen[ch], tcdm_be[ch], tcdm_data[ch]}, r);
            p.due  = cyc + $urandom_range(dly_max, dly_min);
            p.data = rd_force_en ? rd_force : $urandom();
            pend_q[ch].push_back(p);
            exp_rsp_q[ch].push_back(p.data);
            n_grant[ch]++;
          end
        end
        if (in_r_valid[ch]) begin
          chk_eq($sformatf("rsp_expected_ch%0d", ch), exp_rsp_q[ch].size() != 0, 1);
          if (exp_rsp_q[ch].size() != 0) begin
            e = exp_rsp_q[ch].pop_front();
            chk_eq($sformatf("rsp_data_ch%0d", ch), in_r_data[ch], e);
            n_rsp[ch]++;
          end
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int ch = 0; ch < MP; ch++) begin
        if (acc[ch] || !in_req[ch]) begin
          in_req[ch] = 1'b0;
          if (stim_q[ch].size() != 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
            cur_req[ch]  = stim_q[ch].pop_front();
            in_req[ch]   = 1'b1;
            in_add[ch]   = cur_req[ch].add;
            in_wen[ch]   = cur_req[ch].wen;
            in_be[ch]    = cur_req[ch].be;
            in_data[ch]  = cur_req[ch].data;
          end
        end
        tcdm_gnt[ch]     = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_val[ch];
        tcdm_r_valid[ch] = 1'b0;
        tcdm_r_data[ch]  = '0;
        if (spur[ch]) begin
          tcdm_r_valid[ch] = 1'b1;
          tcdm_r_data[ch]  = spur_data;
          exp_rsp_q[ch].push_back(spur_data);
          n_spur[ch]++;
          spur[ch] = 1'b0;
        end else if (pend_q[ch].size() != 0 && pend_q[ch][0].due <= cyc &&
                     (!rsp_hold[ch] || rsp_credit[ch] != 0)) begin
          if (rsp_hold[ch]) rsp_credit[ch]--;
          p = pend_q[ch].pop_front();
          tcdm_r_valid[ch] = 1'b1;
          tcdm_r_data[ch]  = p.data;
        end
      end
    end
  end

  function automatic bit env_empty();
    bit ok = (in_req == '0);
    for (int ch = 0; ch < MP; ch++)
      if (stim_q[ch].size() != 0 || exp_req_q[ch].size() != 0 ||
          pend_q[ch].size() != 0 || exp_rsp_q[ch].size() != 0) ok = 0;
    return ok;
  endfunction

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy_o && env_empty()) begin
        ok = 1;
        break;
      end
    end
    chk_eq({"idle_", tag}, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    bit seen;
    req_t rr;

    // Reset values
    repeat (3) @(negedge clk);
    chk_eq("rst_tcdm_req", tcdm_req, 0);
    chk_eq("rst_in_gnt", in_gnt, 4'hF);
    chk_eq("rst_busy", busy_o, 0);
    chk_eq("rst_err", err_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_tcdm_add", tcdm_add, 0);
    chk_eq("rst_tcdm_data", tcdm_data, 0);
    chk_eq("rst_tcdm_be_wen", {tcdm_be, tcdm_wen}, 0);
    chk_eq("rst_in_r_valid", in_r_valid, 0);
    chk_eq("rst_in_r_data", in_r_data, 0);
    chk_eq("rst_mode", dut.r_mode_q, 0);

    // Single read on ch0
    rd_force_en = 1; rd_force = 32'hDEADBEEF;
    stim_q[0].push_back('{add: 32'h1000, wen: 1'b1, be: 4'hF, data: 32'h0});
    @(negedge clk);
    chk_eq("rd_accept", in_req[0] & in_gnt[0], 1);
    chk_eq("rd_no_fallthrough", tcdm_req[0], 0);
    @(negedge clk);
    chk_eq("rd_tcdm_req", tcdm_req[0], 1);
    chk_eq("rd_tcdm_add", tcdm_add[0], 32'h1000);
    chk_eq("rd_tcdm_wen", tcdm_wen[0], 1);
    @(negedge clk);
    chk_eq("rd_rvalid_not_yet", in_r_valid[0], 0);
    chk_eq("rd_busy", busy_o, 1);
    @(negedge clk);
    chk_eq("rd_rvalid", in_r_valid[0], 1);
    chk_eq("rd_rdata", in_r_data[0], 32'hDEADBEEF);
    chk_eq("rd_busy_clear", busy_o, 0);
    rd_force_en = 0;
    wait_idle("rd");

    // Back-pressure on ch0
    gnt_val[0] = 1'b0;
    for (int i = 0; i < 3; i++)
      stim_q[0].push_back('{add: 32'h100 + 32'(i * 4), wen: 1'(i & 1), be: 4'(4'h3 << i), data: 32'hA000 + 32'(i)});
    @(negedge clk); chk_eq("bp_gnt0", in_gnt[0], 1);
    @(negedge clk); chk_eq("bp_gnt1", in_gnt[0], 1);
    chk_eq("bp_req_held", tcdm_req[0], 1);
    @(negedge clk); chk_eq("bp_full", in_gnt[0], 0);
    chk_eq("bp_third_waits", in_req[0], 1);
    @(negedge clk); chk_eq("bp_still_full", in_gnt[0], 0);
    gnt_val[0] = 1'b1;
    @(negedge clk); chk_eq("bp_no_full_pass", in_gnt[0], 0);
    chk_eq("bp_pop_req", tcdm_req[0] & tcdm_gnt[0], 1);
    @(negedge clk); chk_eq("bp_gnt_reopen", in_gnt[0], 1);
    wait_idle("bp");

    // Outstanding limit on ch1
    rsp_hold[1] = 1'b1; rsp_credit[1] = 0; base = n_grant[1];
    for (int i = 0; i < 6; i++)
      stim_q[1].push_back('{add: 32'h2000 + 32'(i * 4), wen: 1'b1, be: 4'hF, data: 32'h0});
    repeat (12) @(negedge clk);
    chk_eq("os_grants4", n_grant[1] - base, 4);
    chk_eq("os_req_blocked", tcdm_req[1], 0);
    rsp_credit[1] = 1;
    @(negedge clk); chk_eq("os_blocked_on_rsp", tcdm_req[1], 0);
    @(negedge clk); chk_eq("os_one_more", tcdm_req[1], 1);
    @(negedge clk); chk_eq("os_grants5", n_grant[1] - base, 5);
    chk_eq("os_reblocked", tcdm_req[1], 0);
    rsp_hold[1] = 1'b0;
    wait_idle("os");

    // Mode switch while busy on ch3
    rsp_hold[3] = 1'b1; rsp_credit[3] = 0;
    for (int i = 0; i < 2; i++)
      stim_q[3].push_back('{add: 32'h4000 + 32'(i * 4), wen: 1'b1, be: 4'hF, data: 32'h0});
    repeat (5) @(negedge clk);
    bypass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("ms_mode_held", {busy_o, 1'(dut.r_mode_q)}, 2'b10);
    end
    rsp_hold[3] = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy_o) begin seen = 1; break; end
    end
    chk_eq("ms_idle_mode0", {seen, 1'(dut.r_mode_q)}, 2'b10);
    @(negedge clk); chk_eq("ms_mode1", dut.r_mode_q, 1);
    gnt_val[3] = 1'b0;
    stim_q[3].push_back('{add: 32'h3000, wen: 1'b0, be: 4'h5, data: 32'h55AA});
    @(negedge clk);
    chk_eq("byp_req_pass", tcdm_req[3], 1);
    chk_eq("byp_add_pass", tcdm_add[3], 32'h3000);
    chk_eq("byp_gnt_low", in_gnt[3], 0);
    gnt_val[3] = 1'b1;
    @(negedge clk);
    chk_eq("byp_gnt_high", in_gnt[3], 1);
    chk_eq("byp_data_pass", tcdm_data[3], 32'h55AA);
    @(negedge clk); chk_eq("byp_rsp_0lat", in_r_valid[3], 1);
    wait_idle("byp");
    bypass = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("byp_mode_back", dut.r_mode_q, 0);

    // Spurious response on idle ch2
    spur_data = 32'hBAD00002; spur[2] = 1'b1;
    @(negedge clk); chk_eq("sp_err_lat", err_o, 0);
    @(negedge clk); chk_eq("sp_err_set", err_o, 1);
    chk_eq("sp_fwd", in_r_valid[2], 1);
    chk_eq("sp_cnt_zero", busy_o, 0);
    repeat (2) @(negedge clk); chk_eq("sp_err_sticky", err_o, 1);
    @(posedge clk); #1 clear = 1'b1;
    @(negedge clk); chk_eq("sp_err_in_clear", err_o, 1);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk); chk_eq("sp_err_cleared", err_o, 0);

    // Random traffic on all channels
    gnt_rand = 1; gap_en = 1; dly_min = 1; dly_max = 4;
    for (int round = 0; round < 3; round++) begin
      if (round == 1) begin bypass = 1'b1; repeat (2) @(negedge clk); end
      for (int ch = 0; ch < MP; ch++)
        for (int i = 0; i < 30; i++) begin
          rr.add = $urandom(); rr.wen = 1'($urandom_range(0, 1));
          rr.be = 4'($urandom_range(0, 15)); rr.data = $urandom();
          stim_q[ch].push_back(rr);
        end
      wait_idle($sformatf("rnd%0d", round));
      if (round == 1) begin bypass = 1'b0; repeat (2) @(negedge clk); end
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      chk_eq($sformatf("rnd_err_%0d", round), err_o, 0);
    end
    gnt_rand = 0; gap_en = 0;
    for (int ch = 0; ch < MP; ch++)
      chk_eq($sformatf("rsp_count_ch%0d", ch), n_rsp[ch], n_grant[ch] + n_spur[ch]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_tcdm_slice.md
# fir_tcdm_slice

Parametrised per-channel TCDM request/response retiming slice placed between the FIR accelerator's TCDM master ports and the cluster interconnect. It replaces the direct flat-port binding with an MP-channel buffered path. Each channel has a request FIFO, a registered response stage and an outstanding-transaction limiter. A run-time bypass mode is switched only at idle, and a sticky protocol-error flag is provided.

## Interface
Parameters:
- MP, 4: number of TCDM channels.
- AW, 32: address width.
- DW, 32: data width; byte-enable width is DW/8.
- DEPTH, 2: request FIFO entries per channel; power of two, ≥2.
- MAX_OUTST, 4: maximum granted transactions awaiting r_valid per channel; ≥1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of FIFOs and error flag.
- bypass_i  in  1  requested mode; 1 selects combinational pass-through.
- in_req / in_gnt  in/out  [MP]  accelerator-side request handshake.
- in_add  in  [MP][AW]  request address.
- in_wen  in  [MP]  write enable, active-low; 1 means read.
- in_be  in  [MP][DW/8]  byte enables.
- in_data  in  [MP][DW]  write data.
- in_r_data  out  [MP][DW]  response data.
- in_r_valid  out  [MP]  response valid.
- tcdm_req / tcdm_gnt  out/in  [MP]  interconnect-side request handshake.
- tcdm_add, tcdm_wen, tcdm_be, tcdm_data  out  per channel, same widths as the in_* request fields.
- tcdm_r_data  in  [MP][DW]  response data from the interconnect.
- tcdm_r_valid  in  [MP]  response valid from the interconnect.
- busy_o  out  1  high when any channel FIFO is non-empty or any outstanding counter is non-zero.
- err_o  out  1  sticky protocol error.

## Operation
- Protocol, both sides:
  - A request is held stable until granted.
  - Every granted transaction, read or write, returns exactly one r_valid, in order, ≥1 cycle after grant.
- mode_q register, reset 0 (buffered):
  - Loads bypass_i only in cycles where busy_o=0.
  - bypass_i changes while busy are deferred until idle.
- Buffered mode, per channel:
  - in_gnt = FIFO not full. It is independent of tcdm_gnt.
  - Push on in_req & in_gnt, storing {add, wen, be, data}.
  - tcdm_req = FIFO not empty & cnt < MAX_OUTST. tcdm_add/wen/be/data are driven from the FIFO head.
  - Pop on tcdm_req & tcdm_gnt; cnt increments.
  - Response register: in_r_valid ← tcdm_r_valid and in_r_data ← tcdm_r_data, both registered. cnt decrements when tcdm_r_valid is high.
  - cnt width is clog2(MAX_OUTST+1). Increment and decrement in the same cycle leave cnt unchanged.
- Bypass mode (mode_q=1):
  - tcdm_* = in_* and in_gnt = tcdm_gnt, combinationally.
  - in_r_valid/in_r_data = tcdm_r_valid/tcdm_r_data, combinationally.
  - FIFOs and counters stay idle.
- Boundaries:
  - FIFO full: in_gnt=0. A pop in the same cycle does not raise in_gnt until the next cycle; there is no full-pass-through.
  - FIFO empty: a push is not forwarded in the same cycle; there is no empty-fall-through.
  - Push and pop in the same cycle keep occupancy. Pointers wrap modulo DEPTH.
  - cnt=MAX_OUTST: tcdm_req=0 until a response arrives.
  - tcdm_r_valid with cnt=0 in buffered mode: set err_o, leave cnt at 0, still forward the response.
  - clear_i empties FIFOs and clears err_o. cnt is NOT cleared, so issued transactions still retire. clear_i wins over a simultaneous push.
  - Async reset mid-transaction discards all state. The integrator guarantees the interconnect is also reset.

## Timing
- Reset values:
  - tcdm_req=0; tcdm_add/wen/be/data=0.
  - in_r_valid=0, in_r_data=0.
  - in_gnt=1 for every channel (empty FIFO, buffered mode).
  - busy_o=0, err_o=0, mode_q=0, all cnt=0.
- Buffered latency:
  - A request accepted at cycle t appears on tcdm_req at t+1 at the earliest.
  - A response arriving on tcdm_r_valid at cycle r appears on in_r_valid at r+1.
- Throughput: 1 transaction/cycle/channel sustained when tcdm_gnt=1 and DEPTH≥2.
- Bypass latency: 0 cycles on all paths.
- Channels are fully independent. busy_o and the mode switch are global.

## Test plan
- Single read, ch0, tcdm_gnt=1, r_valid at grant+1:
  - in_gnt=1 at t; tcdm_req at t+1 with add=0x1000, wen=1.
  - tcdm_r_data=0xDEADBEEF at t+2; in_r_valid with 0xDEADBEEF at t+3; busy_o returns to 0.
- Back-pressure, DEPTH=2, tcdm_gnt=0, 3 back-to-back requests:
  - First two accepted; in_gnt=0 on the third.
  - After tcdm_gnt=1, all three reach tcdm in order with matching add/be/data.
- Outstanding limit, MAX_OUTST=4, responses withheld:
  - Exactly 4 grants, then tcdm_req=0.
  - One r_valid → one more issue the following cycle.
- Mode switch while busy:
  - bypass_i=1 with 2 transactions pending; mode_q stays 0 until busy_o=0, then becomes 1.
  - Next request passes in the same cycle with in_gnt=tcdm_gnt.
- Spurious tcdm_r_valid on idle ch2: err_o=1 and stays 1; clear_i clears it to 0 the next cycle.
- Random traffic, all MP channels, random gnt/response delays, clear_i pulses at idle: scoreboard sees per-channel in-order data integrity and no lost or duplicated responses.
